// File: rtl/wheel_pulse_conditioner.sv
// Wheel sensor front end: synchronises and debounces the raw Hall input,
// divides accepted rising edges into per-distance-unit motor_cycle pulses,
// and tracks standstill to produce wait_tick pulses for waiting-time billing.
`timescale 1ns/1ps
module wheel_pulse_conditioner #(
    parameter int SYNC_STAGES      = 2,
    parameter int DEBOUNCE_CYCLES  = 16,
    parameter int PULSES_PER_UNIT  = 4,
    parameter int STALL_CYCLES     = 1000,
    parameter int WAIT_TICK_CYCLES = 500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wheel_raw,
    input  logic        enable,
    output logic        motor_cycle,
    output logic        moving,
    output logic        wait_tick,
    output logic [15:0] pulse_total
);

    localparam int CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int DIV_W   = (PULSES_PER_UNIT > 1) ? $clog2(PULSES_PER_UNIT) : 1;
    localparam int STALL_W = $clog2(STALL_CYCLES + 1);
    localparam int WAIT_W  = (WAIT_TICK_CYCLES > 1) ? $clog2(WAIT_TICK_CYCLES) : 1;

    localparam logic [CNT_W-1:0]   DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DIV_W-1:0]   DIV_LAST  = DIV_W'(PULSES_PER_UNIT - 1);
    localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(STALL_CYCLES);
    localparam logic [WAIT_W-1:0]  WAIT_LAST = WAIT_W'(WAIT_TICK_CYCLES - 1);

    typedef enum logic [1:0] {
        S_LOW       = 2'd0,
        S_CONF_HIGH = 2'd1,
        S_HIGH      = 2'd2,
        S_CONF_LOW  = 2'd3
    } deb_state_t;

    // ------------------------------------------------------------------
    // Synchroniser chain: stage gi takes the output of stage gi-1
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_sync;
    logic [SYNC_STAGES-1:0] w_sync_d;
    logic                   w_sync_lvl;

    assign w_sync_d[0] = wheel_raw;

    genvar gi;
    generate
        for (gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
            assign w_sync_d[gi] = r_sync[gi-1];
        end
    endgenerate

    assign w_sync_lvl = r_sync[SYNC_STAGES-1];

    // Shift the raw level through the synchroniser flops
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= w_sync_d;
        end
    end

    // ------------------------------------------------------------------
    // Debounce FSM. The confirm states count consecutive samples of the
    // new level; the last confirming sample moves to the stable state.
    // Only the rising side raises acc, registered for exactly one cycle.
    // ------------------------------------------------------------------
    deb_state_t       r_state, w_state_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_next;
    logic             r_acc, w_acc_next;

    // Debounce next-state and accepted-edge decode
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_acc_next   = 1'b0;
        case (r_state)
            S_LOW: begin
                if (w_sync_lvl) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        w_state_next = S_HIGH;
                        w_cnt_next   = '0;
                        w_acc_next   = 1'b1;
                    end else begin
                        w_state_next = S_CONF_HIGH;
                        w_cnt_next   = CNT_W'(1);
                    end
                end
            end
            S_CONF_HIGH: begin
                if (!w_sync_lvl) begin
                    w_state_next = S_LOW;
                    w_cnt_next   = '0;
                end else if (r_cnt >= DEB_LAST) begin
                    w_state_next = S_HIGH;
                    w_cnt_next   = '0;
                    w_acc_next   = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            S_HIGH: begin
                if (!w_sync_lvl) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        w_state_next = S_LOW;
                        w_cnt_next   = '0;
                    end else begin
                        w_state_next = S_CONF_LOW;
                        w_cnt_next   = CNT_W'(1);
                    end
                end
            end
            S_CONF_LOW: begin
                if (w_sync_lvl) begin
                    w_state_next = S_HIGH;
                    w_cnt_next   = '0;
                end else if (r_cnt >= DEB_LAST) begin
                    w_state_next = S_LOW;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_next = S_LOW;
                w_cnt_next   = '0;
            end
        endcase
    end

    // Debounce state, confirm counter and accepted-edge flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_LOW;
            r_cnt   <= '0;
            r_acc   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_acc   <= w_acc_next;
        end
    end

    // ------------------------------------------------------------------
    // Divider: the wrap is flagged when the completing acc is counted,
    // and motor_cycle is registered from that flag one cycle later.
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] r_div;
    logic             r_wrap;
    logic             r_motor;

    // Count accepted edges per distance unit while the meter runs
    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            r_div  <= '0;
            r_wrap <= 1'b0;
        end else if (r_acc) begin
            if (r_div == DIV_LAST) begin
                r_div  <= '0;
                r_wrap <= 1'b1;
            end else begin
                r_div  <= r_div + DIV_W'(1);
                r_wrap <= 1'b0;
            end
        end else begin
            r_wrap <= 1'b0;
        end
    end

    // Emit the single-cycle motor pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_motor <= 1'b0;
        end else begin
            r_motor <= r_wrap & enable;
        end
    end

    // ------------------------------------------------------------------
    // Stall timer: zero in the acc cycle, then counts up and saturates.
    // Starting saturated makes the vehicle read as stopped after reset.
    // ------------------------------------------------------------------
    logic [STALL_W-1:0] r_stall;
    logic               r_moving;

    // Track cycles since the last accepted edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall <= STALL_MAX;
        end else if (w_acc_next) begin
            r_stall <= '0;
        end else if (r_stall != STALL_MAX) begin
            r_stall <= r_stall + STALL_W'(1);
        end
    end

    // Register the moving flag from the timer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_moving <= 1'b0;
        end else begin
            r_moving <= (r_stall < STALL_MAX);
        end
    end

    // ------------------------------------------------------------------
    // Waiting-time counter: free-runs while stopped and enabled. An acc
    // landing on the terminal cycle clears it without a tick.
    // ------------------------------------------------------------------
    logic [WAIT_W-1:0] r_wait;
    logic              r_tick;

    // Generate periodic wait ticks while stopped
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait <= '0;
            r_tick <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            if (r_acc || r_moving || !enable) begin
                r_wait <= '0;
            end else if (r_wait == WAIT_LAST) begin
                r_wait <= '0;
                r_tick <= 1'b1;
            end else begin
                r_wait <= r_wait + WAIT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Saturating total of accepted rising edges, independent of enable
    // ------------------------------------------------------------------
    logic [15:0] r_total;

    // Count every accepted edge, holding at all-ones
    always_ff @(posedge clk) begin
        if (rst) begin
            r_total <= '0;
        end else if (r_acc && (r_total != 16'hFFFF)) begin
            r_total <= r_total + 16'd1;
        end
    end

    assign motor_cycle = r_motor;
    assign moving      = r_moving;
    assign wait_tick   = r_tick;
    assign pulse_total = r_total;

endmodule

// File: tb/tb_wheel_pulse_conditioner.sv
// Directed bench for wheel_pulse_conditioner with default parameters.
// Cycle numbers: cyc == n right after the n-th rising clock edge.
`timescale 1ns/1ps
module tb_wheel_pulse_conditioner;

    logic        clk = 1'b0;
    logic        rst;
    logic        wheel_raw;
    logic        enable;
    logic        motor_cycle;
    logic        moving;
    logic        wait_tick;
    logic [15:0] pulse_total;

    wheel_pulse_conditioner dut (
        .clk         (clk),
        .rst         (rst),
        .wheel_raw   (wheel_raw),
        .enable      (enable),
        .motor_cycle (motor_cycle),
        .moving      (moving),
        .wait_tick   (wait_tick),
        .pulse_total (pulse_total)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor, sampled mid-cycle on the falling edge
    int n_motor = 0;
    int n_wait = 0;
    int last_motor_cyc = -1;
    int last_wait_cyc = -1;
    int fall_cyc = -1;
    logic prev_moving = 1'b0;
    always @(negedge clk) begin
        if (motor_cycle) begin
            n_motor = n_motor + 1;
            last_motor_cyc = cyc;
        end
        if (wait_tick) begin
            n_wait = n_wait + 1;
            last_wait_cyc = cyc;
        end
        if (prev_moving && !moving) fall_cyc = cyc;
        prev_moving = moving;
    end

    int n_checks = 0;
    int n_errors = 0;
    int last_k = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s = %0d", tag, got);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) tick(1);
    endtask

    // One raw pulse; last_k is the edge that first samples the rise
    task automatic pulse(input int hi, input int lo);
        last_k = cyc + 1;
        wheel_raw = 1'b1;
        tick(hi);
        wheel_raw = 1'b0;
        tick(lo);
    endtask

    int m, k4, k8, a, k, base_m, base_w;

    initial begin
        rst = 1'b1;
        wheel_raw = 1'b0;
        enable = 1'b0;
        tick(1);
        check_eq("rst_motor", motor_cycle, 0);
        check_eq("rst_moving", moving, 0);
        check_eq("rst_wait", wait_tick, 0);
        check_eq("rst_total", pulse_total, 0);
        tick(2);
        rst = 1'b0;

        // 1: idle, then enable while stopped
        base_m = n_motor;
        base_w = n_wait;
        tick(2000);
        check_eq("idle_motor", n_motor - base_m, 0);
        check_eq("idle_wait", n_wait - base_w, 0);
        check_eq("idle_moving", moving, 0);
        m = cyc;
        enable = 1'b1;
        tick(600);
        check_eq("wait_first_cnt", n_wait - base_w, 1);
        check_eq("wait_first_cyc", last_wait_cyc, m + 500);
        tick(500);
        check_eq("wait_second_cnt", n_wait - base_w, 2);
        check_eq("wait_second_cyc", last_wait_cyc, m + 1000);

        // 2: clean 40-cycle square wave, 8 rises
        base_m = n_motor;
        base_w = n_wait;
        for (int i = 0; i < 8; i++) begin
            pulse(20, 20);
            if (i == 3) begin
                k4 = last_k;
                check_eq("motor_after4_cnt", n_motor - base_m, 1);
                check_eq("motor_after4_cyc", last_motor_cyc, k4 + 19);
            end
        end
        k8 = last_k;
        check_eq("motor_after8_cnt", n_motor - base_m, 2);
        check_eq("motor_after8_cyc", last_motor_cyc, k8 + 19);
        check_eq("total_after8", pulse_total, 8);
        check_eq("moving_running", moving, 1);
        check_eq("no_wait_running", n_wait - base_w, 0);

        // 3: short glitches rejected, 16-cycle high accepted
        base_m = n_motor;
        for (int i = 0; i < 3; i++) pulse(5, 15);
        check_eq("glitch_total", pulse_total, 8);
        check_eq("glitch_motor", n_motor - base_m, 0);
        pulse(16, 30);
        a = last_k + 17;
        check_eq("stable16_total", pulse_total, 9);

        // 4: stop, moving falls, wait tick, tick suppressed by edge
        base_w = n_wait;
        wait_until(a + 1100);
        check_eq("moving_fall_cyc", fall_cyc, a + 1001);
        check_eq("stopped_moving", moving, 0);
        check_eq("stop_wait_early", n_wait - base_w, 0);
        wait_until(a + 1600);
        check_eq("stop_wait_cnt", n_wait - base_w, 1);
        check_eq("stop_wait_cyc", last_wait_cyc, a + 1501);
        wait_until(a + 1982);
        wheel_raw = 1'b1;
        tick(20);
        wheel_raw = 1'b0;
        wait_until(a + 2100);
        check_eq("tick_suppressed", n_wait - base_w, 1);
        check_eq("suppress_total", pulse_total, 10);
        check_eq("suppress_moving", moving, 1);

        // 5: edges with enable low, then divider restart
        base_m = n_motor;
        enable = 1'b0;
        for (int i = 0; i < 3; i++) pulse(20, 20);
        check_eq("dis_motor", n_motor - base_m, 0);
        check_eq("dis_total", pulse_total, 13);
        enable = 1'b1;
        for (int i = 0; i < 3; i++) pulse(20, 20);
        check_eq("en3_motor", n_motor - base_m, 0);
        check_eq("en3_total", pulse_total, 16);
        last_k = cyc + 1;
        wheel_raw = 1'b1;
        tick(18);
        enable = 1'b0;
        tick(2);
        wheel_raw = 1'b0;
        tick(20);
        enable = 1'b1;
        check_eq("en_fall_motor", n_motor - base_m, 0);
        check_eq("en_fall_total", pulse_total, 17);
        for (int i = 0; i < 3; i++) pulse(20, 20);
        check_eq("restart3_motor", n_motor - base_m, 0);
        pulse(20, 20);
        k = last_k;
        check_eq("restart4_motor", n_motor - base_m, 1);
        check_eq("restart4_cyc", last_motor_cyc, k + 19);
        check_eq("restart_total", pulse_total, 21);

        // 6: reset mid-operation
        for (int i = 0; i < 3; i++) pulse(20, 20);
        rst = 1'b1;
        tick(1);
        check_eq("mid_rst_total", pulse_total, 0);
        check_eq("mid_rst_moving", moving, 0);
        check_eq("mid_rst_motor", motor_cycle, 0);
        check_eq("mid_rst_wait", wait_tick, 0);
        rst = 1'b0;
        base_m = n_motor;
        base_w = n_wait;
        tick(2);
        check_eq("rst_exit_motor", n_motor - base_m, 0);
        for (int i = 0; i < 3; i++) pulse(20, 20);
        check_eq("post_rst3_motor", n_motor - base_m, 0);
        pulse(20, 20);
        k = last_k;
        check_eq("post_rst4_motor", n_motor - base_m, 1);
        check_eq("post_rst4_cyc", last_motor_cyc, k + 19);
        check_eq("post_rst_total", pulse_total, 4);
        check_eq("post_rst_wait", n_wait - base_w, 0);

        // Saturation: preload the total near the top, then add edges
        @(negedge clk);
        force dut.r_total = 16'hFFFC;
        @(negedge clk);
        release dut.r_total;
        tick(1);
        for (int i = 0; i < 2; i++) pulse(20, 20);
        check_eq("sat_fffe", pulse_total, 16'hFFFE);
        pulse(20, 20);
        check_eq("sat_ffff", pulse_total, 16'hFFFF);
        for (int i = 0; i < 3; i++) pulse(20, 20);
        check_eq("sat_hold", pulse_total, 16'hFFFF);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/wheel_pulse_conditioner.md
Name: wheel_pulse_conditioner

Overview:
Upstream front end for the distance counter. It conditions the raw Hall-effect wheel sensor: synchronise, debounce, divide by sensor pulses per distance unit. It emits the single-cycle motor_cycle pulse consumed by the distance counter. It also detects a stopped vehicle and emits periodic wait_tick pulses for waiting-time billing.

Parameters:
SYNC_STAGES, 2, number of synchroniser flops on wheel_raw (>=2)
DEBOUNCE_CYCLES, 16, consecutive stable cycles required to accept a level change (>=1)
PULSES_PER_UNIT, 4, accepted rising edges per distance unit (>=1)
STALL_CYCLES, 1000, cycles without an accepted edge before the vehicle is declared stopped (>=1)
WAIT_TICK_CYCLES, 500, cycles between wait_tick pulses while stopped and enabled (>=1)

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
wheel_raw  in  1  raw wheel sensor, asynchronous to clk, may bounce
enable  in  1  meter running (fare active); level
motor_cycle  out  1  one-clk pulse per distance unit, to distance counter
moving  out  1  1 while an accepted edge occurred within the last STALL_CYCLES cycles
wait_tick  out  1  one-clk pulse every WAIT_TICK_CYCLES cycles while stopped and enabled
pulse_total  out  16  saturating count of all accepted rising edges since reset

Behaviour:
- Clock is clk. Reset is rst, synchronous and active-high. Single clock domain.
- Reset, on the first clk edge with rst=1:
  - synchroniser flops, debounced level and all counters are cleared.
  - motor_cycle=0, wait_tick=0, moving=0, pulse_total=0.
  - The stall timer is loaded saturated, so the vehicle starts stopped.
  - Reset mid-operation discards any partial divider or wait count. There is no pulse on reset exit.
- Synchroniser: wheel_raw passes through SYNC_STAGES flops, giving sync_lvl.
- Debounce FSM states:
  - LOW: debounced=0; sync_lvl=1 -> CONF_HIGH, cnt=1.
  - CONF_HIGH:
    - sync_lvl=0 -> LOW, cnt=0.
    - Otherwise cnt++. When cnt reaches DEBOUNCE_CYCLES -> HIGH, and an accepted rising edge (acc) is asserted for exactly that one cycle.
  - HIGH: debounced=1; sync_lvl=0 -> CONF_LOW, cnt=1.
  - CONF_LOW: sync_lvl=1 -> HIGH; cnt reaches DEBOUNCE_CYCLES -> LOW; no acc on the falling side.
  - DEBOUNCE_CYCLES=1 means one cycle of stability is sufficient.
- Divider, when enable=1:
  - Each acc increments div.
  - When div would reach PULSES_PER_UNIT, div wraps to 0 and motor_cycle=1 on the next cycle (registered).
  - When enable=0, div is held at 0 and motor_cycle stays 0.
- End-to-end latency: the raw rise is first sampled at edge k. With bounce-free input and enable=1, the completing pulse gives motor_cycle=1 in cycle k+SYNC_STAGES+DEBOUNCE_CYCLES+1.
- Stall timer:
  - acc clears it to 0.
  - Otherwise it increments, saturating at STALL_CYCLES.
  - moving = (timer < STALL_CYCLES), registered. It rises the cycle after acc and falls the cycle after saturation.
- Wait counter:
  - Runs only when moving=0 and enable=1; otherwise held at 0.
  - On reaching WAIT_TICK_CYCLES-1 it wraps to 0 and wait_tick=1 for one cycle.
  - With DEBOUNCE_CYCLES/STALL bounds respected, motor_cycle and wait_tick are never both 1.
- Simultaneous events:
  - acc in the same cycle the wait counter hits terminal: acc wins, so there is no wait_tick and the counter clears.
  - enable falling in the same cycle as a completing acc: no motor_cycle.
  - enable rising: divider starts from 0.
- pulse_total counts every acc regardless of enable. It saturates at 16'hFFFF and never wraps.
- Glitches shorter than DEBOUNCE_CYCLES (after sync) produce no acc, no pulse_total change and no moving change.

Test Plan:
1. Reset then idle, wheel_raw=0 for 2000 cycles: all outputs 0. Then enable=1: wait_tick every 500 cycles, first one 500 cycles after enable.
2. Defaults, enable=1, clean square wave of 40-cycle period for 8 rising edges: 2 motor_cycle pulses, the first at k+2+16+1 of the 4th rise; pulse_total=8; moving=1.
3. Bounce: bursts of 5-cycle high glitches between clean edges: pulse_total and motor_cycle unaffected; a 16-cycle-stable high is accepted.
4. Stop: edges cease. moving falls exactly 1000 cycles after the last acc, wait_tick follows 500 cycles later. An edge arriving on the wait terminal cycle suppresses the tick.
5. enable=0 during 3 edges then enable=1: no motor_cycle; pulse_total still +3; the divider restarts, so 4 further edges are needed for a pulse.
6. Assert rst after 3 edges: everything clears next cycle. After release, 4 new edges are needed for motor_cycle. Force 65540 edges: pulse_total holds 16'hFFFF.
